// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage core.
//
// Merges per-stage stall requests into the stall vector consumed by the
// pipeline registers and sequences exception / eret handling:
//   cycle N   : flush all inter-stage registers
//   cycle N+1 : redirect the PC (pc_load + new_pc) for exactly one cycle
//
// Optional feature: define PIPE_CTRL_WDOG_EN to build a stall watchdog that
// raises a sticky wdog_trip after WDOG_LIMIT consecutive stalled cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   excepttype      exception code from MEM (0 = none)
//   cp0_epc         EPC from CP0, target of eret
//   stall[5:0]      bit k freezes stage k (0=PC .. 5=WB)
//   flush           clear all pipeline registers at the next edge
//   pc_load/new_pc  one-cycle PC redirect
//   wdog_trip       sticky watchdog flag (watchdog builds only)
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
    parameter int          WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] new_pc
`ifdef PIPE_CTRL_WDOG_EN
    ,
    output logic        wdog_trip
`endif
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    if (WDOG_LIMIT < 1) begin : g_bad_limit
        $error("pipe_ctrl: WDOG_LIMIT must be at least 1");
    end

    logic [0:0]  state;
    logic [31:0] target;

    // Outputs are forced quiet while rst is asserted so the pipeline never
    // sees a stall or redirect from a half-reset controller.
    always_comb begin
        stall   = 6'b000000;
        flush   = 1'b0;
        pc_load = 1'b0;
        if (!rst) begin
            if (state == REDIRECT) begin
                // Pipeline holds only bubbles here; requests are ignored.
                pc_load = 1'b1;
            end else if (excepttype != 32'd0) begin
                // Flush wins over every stall request.
                flush = 1'b1;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    assign new_pc = target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            target <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (excepttype != 32'd0) begin
                        state  <= REDIRECT;
                        target <= (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam int             CW  = $clog2(WDOG_LIMIT + 1);
    localparam logic [CW-1:0]  LIM = CW'(WDOG_LIMIT);

    logic [CW-1:0] wdog_cnt;

    // Trip on the same edge the counter reaches the limit, i.e. right after
    // the WDOG_LIMIT-th consecutive stalled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (stall != 6'b000000) begin
            if (wdog_cnt != LIM)
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt >= LIM - 1'b1)
                wdog_trip <= 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype, cp0_epc;
    logic [5:0]  stall;
    logic        flush, pc_load;
    logic [31:0] new_pc;
`ifdef PIPE_CTRL_WDOG_EN
    logic        wdog_trip;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR(32'h0000_0020),
        .ERET_CODE (32'h0000_000e),
        .WDOG_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .excepttype  (excepttype),
        .cp0_epc     (cp0_epc),
        .stall       (stall),
        .flush       (flush),
        .pc_load     (pc_load),
        .new_pc      (new_pc)
`ifdef PIPE_CTRL_WDOG_EN
        ,
        .wdog_trip   (wdog_trip)
`endif
    );

    task automatic clear_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excepttype = 32'd0; cp0_epc = 32'd0;
    endtask

    // Advance to the next falling edge (one rising edge in between).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        clear_inputs();
        rst = 1;
        #2;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        step();
        clear_inputs();
        rst = 1; stallreq_mem = 1;
        #1;
        tests++; if (stall !== 6'b000000) begin fails++; $display("FAIL reset_stall: got %b expected %b", stall, 6'b000000); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush: got %b expected 0", flush); end
        tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL reset_pc_load: got %b expected 0", pc_load); end
        tests++; if (new_pc !== 32'd0) begin fails++; $display("FAIL reset_new_pc: got %h expected 0", new_pc); end
`ifdef PIPE_CTRL_WDOG_EN
        tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL reset_wdog: got %b expected 0", wdog_trip); end
`endif
        step();
        rst = 0;
        #1;
        tests++; if (stall !== 6'b011111) begin fails++; $display("FAIL post_reset_stall: got %b expected %b", stall, 6'b011111); end
        stallreq_mem = 0;
    endtask

    task automatic test_priority();
        step(); clear_inputs(); stallreq_if = 1; #1;
        tests++; if (stall !== 6'b000011) begin fails++; $display("FAIL prio_if: got %b expected %b", stall, 6'b000011); end
        step(); clear_inputs(); stallreq_id = 1; stallreq_ex = 1; #1;
        tests++; if (stall !== 6'b001111) begin fails++; $display("FAIL prio_id_ex: got %b expected %b", stall, 6'b001111); end
        step(); clear_inputs(); stallreq_id = 1; stallreq_if = 1; #1;
        tests++; if (stall !== 6'b000111) begin fails++; $display("FAIL prio_id_if: got %b expected %b", stall, 6'b000111); end
        step(); clear_inputs(); stallreq_mem = 1; stallreq_ex = 1; stallreq_if = 1; #1;
        tests++; if (stall !== 6'b011111) begin fails++; $display("FAIL prio_mem_all: got %b expected %b", stall, 6'b011111); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL prio_flush: got %b expected 0", flush); end
        step(); clear_inputs(); #1;
        tests++; if (stall !== 6'b000000) begin fails++; $display("FAIL prio_none: got %b expected %b", stall, 6'b000000); end
    endtask

    task automatic test_exception();
        step(); clear_inputs(); excepttype = 32'h1; cp0_epc = 32'hdead_beef; #1;
        tests++; if (flush !== 1'b1) begin fails++; $display("FAIL exc_flush: got %b expected 1", flush); end
        tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL exc_n_pc_load: got %b expected 0", pc_load); end
        step(); excepttype = 32'h0; #1;
        tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL exc_pc_load: got %b expected 1", pc_load); end
        tests++; if (new_pc !== 32'h20) begin fails++; $display("FAIL exc_new_pc: got %h expected %h", new_pc, 32'h20); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL exc_n1_flush: got %b expected 0", flush); end
        step(); #1;
        tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL exc_n2_pc_load: got %b expected 0", pc_load); end
        tests++; if (new_pc !== 32'h20) begin fails++; $display("FAIL exc_hold_pc: got %h expected %h", new_pc, 32'h20); end
    endtask

    task automatic test_eret();
        step(); clear_inputs(); excepttype = 32'he; cp0_epc = 32'h0000_1234; #1;
        tests++; if (flush !== 1'b1) begin fails++; $display("FAIL eret_flush: got %b expected 1", flush); end
        step(); clear_inputs(); #1;
        tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL eret_pc_load: got %b expected 1", pc_load); end
        tests++; if (new_pc !== 32'h1234) begin fails++; $display("FAIL eret_new_pc: got %h expected %h", new_pc, 32'h1234); end
        step(); #1;
        tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL eret_end: got %b expected 0", pc_load); end
    endtask

    task automatic test_collision();
        int pulses = 0;
        step(); clear_inputs(); stallreq_mem = 1; excepttype = 32'h8; #1;
        tests++; if (stall !== 6'b000000) begin fails++; $display("FAIL coll_stall: got %b expected %b", stall, 6'b000000); end
        tests++; if (flush !== 1'b1) begin fails++; $display("FAIL coll_flush: got %b expected 1", flush); end
        // Second exception (eret) arrives in the REDIRECT cycle and is dropped.
        step(); excepttype = 32'he; cp0_epc = 32'h0000_5678; #1;
        if (pc_load === 1'b1) pulses++;
        tests++; if (stall !== 6'b000000) begin fails++; $display("FAIL coll_redir_stall: got %b expected %b", stall, 6'b000000); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL coll_redir_flush: got %b expected 0", flush); end
        tests++; if (new_pc !== 32'h20) begin fails++; $display("FAIL coll_new_pc: got %h expected %h", new_pc, 32'h20); end
        step(); excepttype = 32'h0; #1;
        if (pc_load === 1'b1) pulses++;
        tests++; if (stall !== 6'b011111) begin fails++; $display("FAIL coll_resume_stall: got %b expected %b", stall, 6'b011111); end
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            if (pc_load === 1'b1) pulses++;
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL coll_pulses: got %0d expected 1", pulses); end
        stallreq_mem = 0;
    endtask

    task automatic test_back_to_back();
        step(); clear_inputs(); excepttype = 32'h4; #1;
        step(); excepttype = 32'h0; #1;
        tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL b2b_first_load: got %b expected 1", pc_load); end
        // Cycle N+2: a new exception starts a fresh sequence.
        step(); excepttype = 32'he; cp0_epc = 32'h0000_abcd; #1;
        tests++; if (flush !== 1'b1 || pc_load !== 1'b0) begin fails++; $display("FAIL b2b_second_flush: got flush=%b pc_load=%b expected flush=1 pc_load=0", flush, pc_load); end
        step(); clear_inputs(); #1;
        tests++; if (pc_load !== 1'b1 || new_pc !== 32'h0000_abcd) begin fails++; $display("FAIL b2b_second_load: got pc_load=%b new_pc=%h expected 1/%h", pc_load, new_pc, 32'h0000_abcd); end
    endtask

    task automatic test_reset_redirect();
        step(); clear_inputs(); excepttype = 32'h2; #1;
        step(); excepttype = 32'h0; #1;
        tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL rr_pre_load: got %b expected 1", pc_load); end
        #1 rst = 1; #1;
        tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL rr_pc_load: got %b expected 0", pc_load); end
        tests++; if (new_pc !== 32'd0) begin fails++; $display("FAIL rr_new_pc: got %h expected 0", new_pc); end
        step(); rst = 0; #1;
        tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL rr_after: got %b expected 0", pc_load); end
    endtask

`ifdef PIPE_CTRL_WDOG_EN
    task automatic test_watchdog();
        do_reset();
        clear_inputs(); stallreq_ex = 1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL wdog_run1_%0d: got %b expected 0", i, wdog_trip); end
        end
        stallreq_ex = 0;
        step(); #1;
        tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL wdog_gap: got %b expected 0", wdog_trip); end
        stallreq_ex = 1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL wdog_run2_%0d: got %b expected 0", i, wdog_trip); end
        end
        step(); stallreq_ex = 0; #1;
        tests++; if (wdog_trip !== 1'b1) begin fails++; $display("FAIL wdog_trip: got %b expected 1", wdog_trip); end
        tests++; if (stall !== 6'b000000) begin fails++; $display("FAIL wdog_no_effect: got %b expected 0", stall); end
        step(); #1;
        tests++; if (wdog_trip !== 1'b1) begin fails++; $display("FAIL wdog_sticky: got %b expected 1", wdog_trip); end
        rst = 1; #1;
        tests++; if (wdog_trip !== 1'b0) begin fails++; $display("FAIL wdog_rst: got %b expected 0", wdog_trip); end
        step(); rst = 0;
    endtask
`endif

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_priority();
        test_exception();
        test_eret();
        test_collision();
        test_back_to_back();
        test_reset_redirect();
`ifdef PIPE_CTRL_WDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences exception and `eret` handling: it flushes all inter-stage registers, then redirects the PC for exactly one cycle. An optional watchdog flags stalls that never release.

## Interface
- `EXC_VECTOR`, default 32'h0000_0020: PC loaded on any exception other than `eret`.
- `ERET_CODE`, default 32'h0000_000e: `excepttype` value that denotes `eret`.
- `WDOG_LIMIT`, default 1024: stall cycles before the watchdog trips (watchdog builds only).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stallreq_if`  in  1  fetch stage cannot deliver an instruction.
- `stallreq_id`  in  1  ID load-use or operand hazard.
- `stallreq_ex`  in  1  multi-cycle EX operation (mul/div) in progress.
- `stallreq_mem`  in  1  data-side access not complete.
- `excepttype`  in  32  exception code from MEM; zero means no exception.
- `cp0_epc`  in  32  EPC value from CP0, used for `eret`.
- `stall`  out  6  bit k freezes stage k (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).
- `flush`  out  1  clears all pipeline registers at the next edge.
- `pc_load`  out  1  PC takes `new_pc` at the next edge.
- `new_pc`  out  32  redirect target; valid while `pc_load`=1.
- `wdog_trip`  out  1  sticky watchdog flag (watchdog builds only).

## Operation
- FSM states: IDLE, REDIRECT.
- IDLE, `excepttype`≠0: `flush`=1 and `stall`=0 in the same cycle (combinational). At the edge, the FSM latches the target and moves to REDIRECT. The target is `cp0_epc` if `excepttype`==`ERET_CODE`, otherwise `EXC_VECTOR`.
- IDLE, `excepttype`==0: `flush`=0. `stall` is decoded with priority highest stage first:
  - `stallreq_mem` -> 6'b011111
  - else `stallreq_ex` -> 6'b001111
  - else `stallreq_id` -> 6'b000111
  - else `stallreq_if` -> 6'b000011
  - else 6'b000000
- REDIRECT: `pc_load`=1, `new_pc`=latched target, `flush`=0, `stall`=0. All stall requests and `excepttype` are ignored because the pipeline holds only bubbles. The FSM returns to IDLE at the next edge.
- `new_pc` holds its last latched value outside REDIRECT. It is only meaningful when `pc_load`=1.
- Flush overrides stall: an exception concurrent with any stall request produces `stall`=0, `flush`=1.
- Reset (any time, including mid-REDIRECT): state=IDLE, latched target=0. Outputs then follow the IDLE rules with no stall requests and `excepttype`=0: `stall`=0, `flush`=0, `pc_load`=0, `new_pc`=0, `wdog_trip`=0.

## Timing
- Stall and flush decoding has 0-cycle latency; the pipeline registers sample `stall` and `flush` at the same edge.
- Exception sequence is fixed at 2 cycles:
  - cycle N: `flush` high.
  - cycle N+1: `pc_load` high with the target.
  - cycle N+2: normal operation.
- Back-to-back exceptions: one arriving in N+1 is dropped. One arriving in N+2 starts a new sequence.
- `excepttype` is sampled only in IDLE. `cp0_epc` is sampled at the edge ending cycle N.

## Configuration
- `PIPE_CTRL_WDOG_EN` defined:
  - A counter of `$clog2(WDOG_LIMIT+1)` bits increments each cycle with `stall`≠0.
  - It clears on any cycle with `stall`==0.
  - It saturates at `WDOG_LIMIT`.
  - On reaching `WDOG_LIMIT`, `wdog_trip` sets and stays set until `rst`.
  - The watchdog has no effect on the stall or flush outputs.
- `PIPE_CTRL_WDOG_EN` undefined: no counter, and the `wdog_trip` port is absent.

## Test plan
- Reset: hold `rst`=1 with `stallreq_mem`=1 -> `stall`=0, `flush`=0, `pc_load`=0, `new_pc`=0. After release with `stallreq_mem`=1 -> `stall`=6'b011111.
- Stall priority: `stallreq_if`=1 alone -> 6'b000011. Then `stallreq_id`=1 and `stallreq_ex`=1 together -> 6'b001111.
- Exception: `excepttype`=32'h1 for one cycle -> `flush`=1 that cycle. Next cycle `pc_load`=1, `new_pc`=32'h20. Then `pc_load`=0.
- Eret: `excepttype`=32'he, `cp0_epc`=32'h0000_1234 -> flush cycle, then `new_pc`=32'h1234 with `pc_load`=1.
- Collision: `stallreq_mem`=1 with `excepttype`=32'h8 -> `stall`=0, `flush`=1. A second exception in the REDIRECT cycle is ignored, and exactly one `pc_load` pulse is produced.
- Watchdog (`PIPE_CTRL_WDOG_EN`, `WDOG_LIMIT`=4): hold `stallreq_ex` for 3 cycles, drop it for 1, then hold it for 4 -> `wdog_trip` rises only after the 4th consecutive stall cycle. Apply `rst` mid-REDIRECT -> `pc_load`=0 immediately.
